// File: rtl/vend_coin_sched.sv
// Coin-slot front end for vending_machine: round-robin slot arbitration,
// a small coin FIFO, one-at-a-time feeding with dispense hold-off, and
// saturating vend/change statistics.
module vend_coin_sched #(
  parameter int unsigned NUM_SLOTS    = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DISPENSE_CYC = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SLOTS-1:0]          slot_valid,
  input  logic [2*NUM_SLOTS-1:0]        slot_coin,
  output logic [NUM_SLOTS-1:0]          slot_ready,
  output logic [1:0]                    vm_in,
  input  logic                          vm_out,
  input  logic [1:0]                    vm_change,
  output logic                          busy,
  output logic                          coin_reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    vend_count,
  output logic [7:0]                    change_count
);

  localparam int unsigned PTR_W  = $clog2(NUM_SLOTS);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = AW + 1;
  localparam int unsigned HOLD_W = (DISPENSE_CYC > 1) ? $clog2(DISPENSE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FEED     = 2'd1,
    S_CHECK    = 2'd2,
    S_DISPENSE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant;
  logic [PTR_W-1:0]    idx;
  logic                grant_vld;
  logic [1:0]          grant_coin;
  logic                coin_legal;
  logic                fifo_room;
  logic                take_legal;
  logic                take_illegal;
  logic                push;
  logic                pop;
  logic [1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [HOLD_W-1:0]   hold;
  logic [1:0]          vm_in_d;
  logic                busy_d;
  logic                vend_inc;
  logic                change_inc;
  logic [1:0]          coin_arr [NUM_SLOTS];

  // Unpack the flat coin bus into per-slot codes
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_coin
    assign coin_arr[g] = slot_coin[2*g +: 2];
  end

  // Round-robin grant: first valid slot at or after rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      idx = PTR_W'((32'(rr_ptr) + k) % NUM_SLOTS);
      if (!grant_vld && slot_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // Accept/reject decision; a pop in FEED frees a slot for a same-cycle push
  always_comb begin
    pop          = (state == S_FEED);
    grant_coin   = coin_arr[grant];
    coin_legal   = (grant_coin == 2'b01) || (grant_coin == 2'b10);
    fifo_room    = (fifo_count != CNT_W'(FIFO_DEPTH)) || pop;
    take_legal   = grant_vld && coin_legal && fifo_room;
    take_illegal = grant_vld && !coin_legal;
    push         = take_legal;
    coin_reject  = take_illegal;
    slot_ready   = '0;
    if (take_legal || take_illegal) begin
      slot_ready[grant] = 1'b1;
    end
  end

  // Round-robin pointer moves past any slot whose coin was consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (take_legal || take_illegal) begin
      rr_ptr <= PTR_W'((32'(grant) + 1) % NUM_SLOTS);
    end
  end

  // Coin storage; contents need no reset since fifo_count qualifies them
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= grant_coin;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (fifo_count != '0) state_d = S_FEED;
      S_FEED:     state_d = S_CHECK;
      S_CHECK:    state_d = vm_out ? S_DISPENSE : S_IDLE;
      S_DISPENSE: if (hold == '0) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode; vm_in/busy are computed from the next state and registered
  always_comb begin
    vm_in_d    = 2'b00;
    busy_d     = (state_d != S_IDLE);
    vend_inc   = (state == S_CHECK) && vm_out;
    change_inc = vend_inc && (vm_change != 2'b00);
    if (state_d == S_FEED) begin
      vm_in_d = mem[rd_ptr];
    end
  end

  // Registered outputs, dispense hold-off and saturating statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vm_in        <= 2'b00;
      busy         <= 1'b0;
      hold         <= '0;
      vend_count   <= 8'd0;
      change_count <= 8'd0;
    end else begin
      vm_in <= vm_in_d;
      busy  <= busy_d;
      if (vend_inc) begin
        hold <= HOLD_W'(DISPENSE_CYC - 1);
      end else if ((state == S_DISPENSE) && (hold != '0)) begin
        hold <= hold - HOLD_W'(1);
      end
      if (vend_inc && (vend_count != 8'hFF)) begin
        vend_count <= vend_count + 8'd1;
      end
      if (change_inc && (change_count != 8'hFF)) begin
        change_count <= change_count + 8'd1;
      end
    end
  end

endmodule
